fir_ctrl_regs: RTL and testbench

Register file and run controller that sits directly downstream of the APB bridge on its internal peripheral bus (p_address/p_data/p_wr/p_data_back).
- Holds the FIR control, status and length registers and a 32-entry coefficient bank.
- Launches FIR runs, counts processed samples and raises a done interrupt.
- The FIR datapath reads coefficients through a separate read port.

---
 rtl/fir_regs_pkg.sv | 18 +
 rtl/fir_coef_bank.sv | 26 ++
 rtl/fir_ctrl_regs.sv | 102 ++++++++++
 tb/tb_fir_ctrl_regs.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fir_regs_pkg.sv
// fir_regs_pkg: address map, register bit indices and run states shared by the FIR register block
package fir_regs_pkg;
   localparam int ADDR_CTRL     = 0;
   localparam int ADDR_STATUS   = 1;
   localparam int ADDR_LEN      = 2;
   localparam int ADDR_NTAPS    = 3;
   localparam int ADDR_PROGRESS = 4;
   localparam int ADDR_ID       = 5;
   localparam int COEF_BASE     = 32;
   localparam int CTRL_START    = 0;
   localparam int CTRL_SOFT_RST = 1;
   localparam int CTRL_IRQ_EN   = 2;
   localparam int ST_BUSY       = 0;
   localparam int ST_DONE       = 1;
   localparam int ST_ERR        = 2;
   localparam logic [15:0] ID_VALUE = 16'hF1A0;
   typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: coefficient array with one write port and two combinational read ports
module fir_coef_bank #(
   parameter int DATA_W    = 16,
   parameter int NTAPS_MAX = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [4:0]        widx_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [4:0]        ra_idx_i,
   output logic [DATA_W-1:0] ra_data_o,
   input  logic [4:0]        rb_idx_i,
   output logic [DATA_W-1:0] rb_data_o
);
   localparam int IW = $clog2(NTAPS_MAX);
   logic [DATA_W-1:0] mem_q [NTAPS_MAX];
   always_ff @(posedge clk_i) begin
      if (rst_i)
         for (int i = 0; i < NTAPS_MAX; i++) mem_q[i] <= '0;
      else if (we_i && int'(widx_i) < NTAPS_MAX)
         mem_q[widx_i[IW-1:0]] <= wdata_i;
   end
   assign ra_data_o = (int'(ra_idx_i) < NTAPS_MAX) ? mem_q[ra_idx_i[IW-1:0]] : '0;
   assign rb_data_o = (int'(rb_idx_i) < NTAPS_MAX) ? mem_q[rb_idx_i[IW-1:0]] : '0;
endmodule

// File: rtl/fir_ctrl_regs.sv
// fir_ctrl_regs: FIR control/status registers, coefficient bank and run controller on the peripheral bus
module fir_ctrl_regs #(
   parameter int                DATA_W    = 16,
   parameter int                ADDR_W    = 6,
   parameter int                NTAPS_MAX = 32,
   parameter logic [DATA_W-1:0] ID_VALUE  = fir_regs_pkg::ID_VALUE
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic [ADDR_W-1:0] p_address,
   input  logic [DATA_W-1:0] p_data,
   input  logic              p_wr,
   output logic [DATA_W-1:0] p_data_back,
   input  logic [4:0]        coef_raddr,
   output logic [DATA_W-1:0] coef_rdata,
   output logic              fir_start,
   output logic [DATA_W-1:0] fir_len,
   output logic [5:0]        fir_ntaps,
   input  logic              fir_sample_done,
   output logic              irq
);
   import fir_regs_pkg::*;
   state_e            state_q, state_d;
   logic [DATA_W-1:0] len_q, len_d, prog_q, prog_d, rdata_d, coef_rd;
   logic [5:0]        ntaps_q, ntaps_d;
   logic              irq_en_q, irq_en_d, done_q, done_d, err_q, err_d, start_q, start_d;
   logic              busy, coef_sel, wr_ctrl, wr_status, wr_len, wr_ntaps, wr_coef;
   logic              start_req, soft_rst, cfg_ok, last;
   assign busy      = state_q == RUN;
   assign coef_sel  = p_address[ADDR_W-1:5] == (ADDR_W-5)'(COEF_BASE >> 5);
   assign wr_ctrl   = p_wr && p_address == ADDR_W'(ADDR_CTRL);
   assign wr_status = p_wr && p_address == ADDR_W'(ADDR_STATUS);
   assign wr_len    = p_wr && p_address == ADDR_W'(ADDR_LEN);
   assign wr_ntaps  = p_wr && p_address == ADDR_W'(ADDR_NTAPS);
   assign wr_coef   = p_wr && coef_sel;
   assign start_req = wr_ctrl && p_data[CTRL_START];
   assign soft_rst  = wr_ctrl && p_data[CTRL_SOFT_RST];
   assign cfg_ok    = ntaps_q != 0 && int'(ntaps_q) <= NTAPS_MAX && len_q != 0;
   assign last      = busy && fir_sample_done && prog_q + DATA_W'(1) == len_q;
   fir_coef_bank #(.DATA_W(DATA_W), .NTAPS_MAX(NTAPS_MAX)) u_bank (
      .clk_i(PCLK), .rst_i(PRESET), .we_i(wr_coef && !busy), .widx_i(p_address[4:0]),
      .wdata_i(p_data), .ra_idx_i(p_address[4:0]), .ra_data_o(coef_rd),
      .rb_idx_i(coef_raddr), .rb_data_o(coef_rdata));
   // later assignments take priority: completion beats DONE clear, SOFT_RST beats everything
   always_comb begin
      state_d  = state_q;
      prog_d   = prog_q;
      len_d    = (wr_len && !busy) ? p_data : len_q;
      ntaps_d  = (wr_ntaps && !busy) ? p_data[5:0] : ntaps_q;
      irq_en_d = wr_ctrl ? p_data[CTRL_IRQ_EN] : irq_en_q;
      done_d   = done_q && !(wr_status && p_data[ST_DONE]);
      err_d    = (err_q && !(wr_status && p_data[ST_ERR]))
               || (busy && (wr_len || wr_ntaps || wr_coef || start_req))
               || (start_req && !busy && !cfg_ok);
      start_d  = start_req && !busy && cfg_ok && !soft_rst;
      if (busy && fir_sample_done) prog_d = prog_q + DATA_W'(1);
      if (last) begin state_d = IDLE; done_d = 1'b1; end
      if (start_d) begin state_d = RUN; prog_d = '0; done_d = 1'b0; end
      if (soft_rst) begin state_d = IDLE; prog_d = '0; done_d = 1'b0; err_d = 1'b0; end
   end
   always_comb begin
      rdata_d = '0;
      if (coef_sel) rdata_d = coef_rd;
      else case (p_address)
         ADDR_W'(ADDR_CTRL):     rdata_d[CTRL_IRQ_EN] = irq_en_q;
         ADDR_W'(ADDR_STATUS):   rdata_d[2:0] = {err_q, done_q, busy};
         ADDR_W'(ADDR_LEN):      rdata_d = len_q;
         ADDR_W'(ADDR_NTAPS):    rdata_d[5:0] = ntaps_q;
         ADDR_W'(ADDR_PROGRESS): rdata_d = prog_q;
         ADDR_W'(ADDR_ID):       rdata_d = ID_VALUE;
         default:                rdata_d = '0;
      endcase
   end
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= IDLE;
         prog_q      <= '0;
         len_q       <= '0;
         ntaps_q     <= '0;
         irq_en_q    <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         start_q     <= 1'b0;
         irq         <= 1'b0;
         p_data_back <= '0;
      end else begin
         state_q     <= state_d;
         prog_q      <= prog_d;
         len_q       <= len_d;
         ntaps_q     <= ntaps_d;
         irq_en_q    <= irq_en_d;
         done_q      <= done_d;
         err_q       <= err_d;
         start_q     <= start_d;
         irq         <= irq_en_q && done_q;
         p_data_back <= rdata_d;
      end
   end
   assign fir_start = start_q;
   assign fir_len   = len_q;
   assign fir_ntaps = ntaps_q;
endmodule

// File: tb/tb_fir_ctrl_regs.sv
// tb_fir_ctrl_regs: directed bus traffic checked against a behavioural register-file model
module tb_fir_ctrl_regs;
   logic        PCLK = 0, PRESET = 1, p_wr = 0, fir_sample_done = 0;
   logic [5:0]  p_address = 0;
   logic [15:0] p_data = 0;
   logic [4:0]  coef_raddr = 0;
   logic [15:0] p_data_back, coef_rdata, fir_len, v;
   logic [5:0]  fir_ntaps;
   logic        fir_start, irq;
   int          checks = 0, errors = 0;
   bit          chk_en = 0;
   logic [15:0] m_len, m_prog, exp_rd;
   logic [15:0] m_coef [32];
   logic [5:0]  m_ntaps;
   bit          m_run, m_done, m_err, m_irq_en, exp_start, exp_irq;

   always #5 PCLK = ~PCLK;

   fir_ctrl_regs dut (
      .PCLK(PCLK), .PRESET(PRESET), .p_address(p_address), .p_data(p_data), .p_wr(p_wr),
      .p_data_back(p_data_back), .coef_raddr(coef_raddr), .coef_rdata(coef_rdata),
      .fir_start(fir_start), .fir_len(fir_len), .fir_ntaps(fir_ntaps),
      .fir_sample_done(fir_sample_done), .irq(irq));

   function automatic logic [15:0] model_read(input logic [5:0] a);
      if (a[5]) return m_coef[a[4:0]];
      case (a)
         6'd0:    return {13'd0, m_irq_en, 2'd0};
         6'd1:    return {13'd0, m_err, m_done, m_run};
         6'd2:    return m_len;
         6'd3:    return {10'd0, m_ntaps};
         6'd4:    return m_prog;
         6'd5:    return 16'hF1A0;
         default: return 16'h0000;
      endcase
   endfunction

   always @(posedge PCLK) begin
      bit busy, wc, ws, start;
      if (PRESET) begin
         m_len = 0; m_prog = 0; m_ntaps = 0;
         m_run = 0; m_done = 0; m_err = 0; m_irq_en = 0;
         for (int i = 0; i < 32; i++) m_coef[i] = 0;
         exp_rd = 0; exp_start = 0; exp_irq = 0;
      end else begin
         exp_rd    = model_read(p_address);
         exp_irq   = m_irq_en && m_done;
         exp_start = 0;
         busy  = m_run;
         wc    = p_wr && p_address == 0;
         ws    = p_wr && p_address == 1;
         start = wc && p_data[0];
         if (wc) m_irq_en = p_data[2];
         if (ws && p_data[1]) m_done = 0;
         if (ws && p_data[2]) m_err = 0;
         if (p_wr && (p_address == 2 || p_address == 3 || p_address[5] || start)) begin
            if (busy && !(wc && !start)) m_err = 1;
            else if (p_address == 2) m_len = p_data;
            else if (p_address == 3) m_ntaps = p_data[5:0];
            else if (p_address[5]) m_coef[p_address[4:0]] = p_data;
         end
         if (busy && fir_sample_done) begin
            m_prog = m_prog + 1;
            if (m_prog == m_len) begin m_run = 0; m_done = 1; end
         end
         if (!busy && start) begin
            if (m_ntaps >= 1 && m_ntaps <= 32 && m_len != 0) begin
               m_run = 1; m_prog = 0; m_done = 0; exp_start = 1;
            end else m_err = 1;
         end
         if (wc && p_data[1]) begin
            m_run = 0; m_prog = 0; m_done = 0; m_err = 0; exp_start = 0;
         end
      end
   end

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   always @(negedge PCLK) if (chk_en) begin
      check("p_data_back", p_data_back, exp_rd);
      check("fir_start", 16'(fir_start), 16'(exp_start));
      check("irq", 16'(irq), 16'(exp_irq));
      check("coef_rdata", coef_rdata, m_coef[coef_raddr]);
      check("fir_len", fir_len, m_len);
      check("fir_ntaps", 16'(fir_ntaps), 16'(m_ntaps));
   end

   task automatic tick();
      @(posedge PCLK); #1;
   endtask
   task automatic rd(input logic [5:0] a, output logic [15:0] d);
      p_address = a; p_wr = 0; tick(); d = p_data_back;
   endtask
   task automatic wr(input logic [5:0] a, input logic [15:0] d);
      p_address = a; p_data = d; p_wr = 1; tick(); p_wr = 0;
   endtask
   task automatic pulse(input int n);
      for (int k = 0; k < n; k++) begin fir_sample_done = 1; tick(); fir_sample_done = 0; end
   endtask

   initial begin
      repeat (2) @(posedge PCLK);
      #1 PRESET = 0; chk_en = 1;
      rd(5, v); check("id", v, 16'hF1A0);
      rd(1, v); check("status_rst", v, 16'h0000);
      check("irq_rst", 16'(irq), 16'h0000);
      for (int i = 0; i < 32; i++) wr(6'(32 + i), 16'(i * 16'h0101));
      for (int i = 0; i < 32; i++) begin
         rd(6'(32 + i), v); check("coef_rb", v, 16'(i * 16'h0101));
      end
      coef_raddr = 7; #1 check("coef_port", coef_rdata, 16'h0707);
      wr(2, 4); wr(3, 8); wr(0, 5);
      check("start_pulse", 16'(fir_start), 16'h0001);
      pulse(3);
      rd(1, v); check("busy_run", v, 16'h0001);
      pulse(1);
      rd(4, v); check("progress", v, 16'h0004);
      check("irq_up", 16'(irq), 16'h0001);
      rd(1, v); check("status_done", v, 16'h0002);
      wr(1, 2); tick(); check("irq_down", 16'(irq), 16'h0000);
      wr(3, 0); wr(0, 1); check("no_start_nt0", 16'(fir_start), 16'h0000);
      rd(1, v); check("err_nt0", v, 16'h0004); wr(1, 4);
      wr(3, 33); wr(0, 1); rd(1, v); check("err_nt33", v, 16'h0004); wr(1, 4);
      wr(3, 8); wr(2, 0); wr(0, 1); rd(1, v); check("err_len0", v, 16'h0004);
      wr(1, 4); rd(1, v); check("err_clr", v, 16'h0000);
      wr(2, 4); wr(0, 1); wr(33, 16'hBEEF); wr(2, 9);
      rd(33, v); check("coef_locked", v, 16'h0101);
      rd(2, v); check("len_locked", v, 16'h0004);
      rd(1, v); check("busy_err", v, 16'h0005);
      wr(0, 2); rd(1, v); check("srst_status", v, 16'h0000);
      rd(4, v); check("srst_prog", v, 16'h0000);
      wr(0, 1); pulse(3);
      p_address = 1; p_data = 2; p_wr = 1; fir_sample_done = 1; tick();
      p_wr = 0; fir_sample_done = 0;
      rd(1, v); check("done_wins", v, 16'h0002);
      wr(1, 2); wr(0, 1); pulse(3);
      p_address = 0; p_data = 2; p_wr = 1; fir_sample_done = 1; tick();
      p_wr = 0; fir_sample_done = 0;
      rd(1, v); check("srst_wins", v, 16'h0000);
      rd(4, v); check("srst_wins_prog", v, 16'h0000);
      wr(0, 5); pulse(2);
      PRESET = 1; tick(); PRESET = 0;
      check("rst_start", 16'(fir_start), 16'h0000);
      check("rst_irq", 16'(irq), 16'h0000);
      check("rst_len", fir_len, 16'h0000);
      rd(1, v); check("rst_status", v, 16'h0000);
      rd(33, v); check("rst_coef", v, 16'h0000);
      rd(0, v); check("rst_ctrl", v, 16'h0000);
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
